// File: rtl/three_wire_pkg.sv
// Shared definitions for the three-wire serial writer and receiver:
// default word size, receiver state encoding and bit-counter sizing.
package three_wire_pkg;

    localparam int TW_WORD_BITS = 16;

    typedef enum logic [2:0] {
        ST_ARM,
        ST_IDLE,
        ST_SHIFT,
        ST_DONE,
        ST_OVER
    } tw_state_e;

    // Counter must be able to hold the value WORD_BITS itself, not just WORD_BITS-1.
    function automatic int twCountWidth(input int bits);
        return $clog2(bits + 1);
    endfunction

    localparam int TW_CNT_W = twCountWidth(TW_WORD_BITS);

endpackage

// File: rtl/three_wire_sync.sv
// Two-flop synchronizer for one asynchronous pin, with an optional third
// flop that turns the synchronized level into rise/fall pulses.
module three_wire_sync #(
    parameter bit RESET_VAL   = 1'b0,
    parameter bit EDGE_DETECT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

    generate
        if (EDGE_DETECT) begin : g_edge
            logic r_prev;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_prev <= RESET_VAL;
                end else begin
                    r_prev <= r_sync;
                end
            end

            assign o_rise = r_sync & ~r_prev;
            assign o_fall = ~r_sync & r_prev;
        end else begin : g_noEdge
            assign o_rise = 1'b0;
            assign o_fall = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/three_wire_rx.sv
// Peripheral-side three-wire deserializer: oversamples cs/sclk/sdi with clk,
// reassembles MSB-first words and flags short or overlong frames.
module three_wire_rx
    import three_wire_pkg::*;
#(
    parameter int WORD_BITS     = TW_WORD_BITS,
    parameter bit CS_ACTIVE_LOW = 1'b1,
    parameter bit SAMPLE_RISING = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cs,
    input  logic                 sclk,
    input  logic                 sdi,
    output logic [WORD_BITS-1:0] data_out,
    output logic                 valid,
    output logic                 busy,
    output logic                 frame_err
);

    localparam int CNT_W = twCountWidth(WORD_BITS);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(WORD_BITS);

    logic w_csSync;
    logic w_sclkRise;
    logic w_sclkFall;
    logic w_sclkLevelUnused;
    logic w_sdiSync;
    logic w_unusedCsRise;
    logic w_unusedCsFall;
    logic w_unusedSdiRise;
    logic w_unusedSdiFall;
    logic w_csAct;
    logic w_sampleEdge;

    tw_state_e              r_state;
    logic [CNT_W-1:0]       r_count;
    logic [WORD_BITS-1:0]   r_shift;

    // cs resets to its asserted level so ARM only releases once the pin is really seen idle.
    three_wire_sync #(
        .RESET_VAL   (~CS_ACTIVE_LOW),
        .EDGE_DETECT (1'b0)
    ) u_csSync (
        .clk     (clk),
        .rst     (rst),
        .i_async (cs),
        .o_sync  (w_csSync),
        .o_rise  (w_unusedCsRise),
        .o_fall  (w_unusedCsFall)
    );

    three_wire_sync #(
        .RESET_VAL   (1'b0),
        .EDGE_DETECT (1'b1)
    ) u_sclkSync (
        .clk     (clk),
        .rst     (rst),
        .i_async (sclk),
        .o_sync  (w_sclkLevelUnused),
        .o_rise  (w_sclkRise),
        .o_fall  (w_sclkFall)
    );

    // Same depth as sclk's level path, so sdi lines up with the edge pulse.
    three_wire_sync #(
        .RESET_VAL   (1'b0),
        .EDGE_DETECT (1'b0)
    ) u_sdiSync (
        .clk     (clk),
        .rst     (rst),
        .i_async (sdi),
        .o_sync  (w_sdiSync),
        .o_rise  (w_unusedSdiRise),
        .o_fall  (w_unusedSdiFall)
    );

    assign w_csAct      = w_csSync ^ CS_ACTIVE_LOW;
    assign w_sampleEdge = SAMPLE_RISING ? w_sclkRise : w_sclkFall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_ARM;
            r_count   <= '0;
            r_shift   <= '0;
            data_out  <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            case (r_state)
                ST_ARM: begin
                    if (!w_csAct) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (w_csAct) begin
                        r_count <= '0;
                        r_shift <= '0;
                        busy    <= 1'b1;
                        r_state <= ST_SHIFT;
                    end
                end
                // A full word wins over a cs release seen in the same cycle.
                ST_SHIFT: begin
                    if (r_count == FULL_COUNT) begin
                        data_out <= r_shift;
                        valid    <= 1'b1;
                        r_state  <= ST_DONE;
                    end else if (!w_csAct) begin
                        frame_err <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else if (w_sampleEdge) begin
                        r_shift <= {r_shift[WORD_BITS-2:0], w_sdiSync};
                        r_count <= r_count + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!w_csAct) begin
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_sampleEdge) begin
                        frame_err <= 1'b1;
                        r_state   <= ST_OVER;
                    end
                end
                ST_OVER: begin
                    if (!w_csAct) begin
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_ARM;
                end
            endcase
        end
    end

endmodule

// File: doc/three_wire_rx.md
Name: three_wire_rx

Overview:
Receive-side counterpart of the team's three_wire serial writer: a peripheral-end deserializer that samples the cs/sclk/data triplet with the system clock.
- Reassembles WORD_BITS-bit words, MSB first.
- Presents each completed word on a parallel bus with a one-cycle valid strobe.
- Used for loopback verification of the writer and for accepting commands from an external three-wire master.

Parameters:
WORD_BITS, 16, bits per frame; data_out width
CS_ACTIVE_LOW, 1, 1 = cs asserted when low; 0 = asserted when high
SAMPLE_RISING, 1, 1 = capture sdi on sclk rising edge; 0 = falling edge

Ports:
clk  in  1  system clock; all logic on posedge clk
rst  in  1  synchronous reset, active-high
cs  in  1  chip select from master, asynchronous to clk
sclk  in  1  serial clock from master, asynchronous to clk
sdi  in  1  serial data from master, asynchronous to clk
data_out  out  WORD_BITS  last complete word received
valid  out  1  one-cycle pulse: data_out updated this cycle
busy  out  1  high while a frame is in progress (cs asserted and armed)
frame_err  out  1  one-cycle pulse: frame aborted or overlong

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: data_out = 0, valid = 0, busy = 0, frame_err = 0, bit count = 0, state = ARM.
- Synchronizers: cs, sclk and sdi each pass through a 2-flop synchronizer.
  - sclk gets a third flop for edge detection.
  - sdi is delayed to stay aligned with the sclk edge pulse.
  - Capture latency: 3 clk cycles from pin edge to shift.
- Input timing requirement: sclk high and low phases each ≥ 3 clk periods, and sdi stable across the sampling edge. Otherwise behaviour is undefined.
- cs_act = synced cs XOR CS_ACTIVE_LOW. Sample edge is selected by SAMPLE_RISING.
- State ARM (after reset): wait for cs_act = 0, then go to IDLE. This prevents capturing a partial frame after reset mid-transfer.
- State IDLE: on cs_act = 1, clear bit count and shift reg, then go to SHIFT. busy = 1 from the next cycle.
- State SHIFT:
  - On each sample edge with cs_act = 1, shift reg = {shift reg[WORD_BITS-2:0], sdi} and increment count.
  - When count reaches WORD_BITS, the next cycle loads data_out from the shift reg, pulses valid for exactly 1 cycle, and goes to DONE.
  - If cs_act drops with count < WORD_BITS: pulse frame_err, leave data_out unchanged, go to IDLE.
- State DONE:
  - cs_act = 0 → IDLE, busy = 0.
  - A further sample edge while cs_act = 1 → pulse frame_err once (overlong frame) and go to OVER. Extra bits are discarded.
- State OVER: ignore all edges; on cs_act = 0 → IDLE.
- Edge and cs release in the same synced cycle: the edge is ignored.
  - In SHIFT this makes the frame short → frame_err.
  - In DONE it is a clean end.
- Sample edges in IDLE or ARM are ignored. sclk may idle at either level.
- Back-to-back frames: cs deasserted for ≥ 3 clk cycles is required to return to IDLE before the next frame.
- data_out holds its value until the next valid.
- valid and frame_err are never high in the same cycle.

Decomposition:
- Shared package three_wire_pkg:
  - WORD_BITS default constant (16), shared with the three_wire writer.
  - State enum: ARM, IDLE, SHIFT, DONE, OVER.
  - Bit-count width constant: $clog2(WORD_BITS+1).
- One sub-module, three_wire_sync:
  - Parameterizable 2-flop synchronizer plus optional edge-detect flop.
  - Instantiated for cs, sclk (with edge outputs) and sdi.

Test Plan:
- Reset then frame 16'b0101_0101_1111_0000, CS low, sclk = clk/8, rising sample → one valid pulse, data_out = 16'h55F0, frame_err = 0, busy high only during frame.
- Two consecutive frames 16'hA5C3 then 16'h0001, 4-cycle cs gap → two valid pulses, data_out = 16'hA5C3 then 16'h0001.
- cs released after 9 bits of 16'hFFFF (prior data_out = 16'h55F0) → frame_err pulse, no valid, data_out remains 16'h55F0, busy = 0 afterwards.
- 17 sclk edges in one cs window, data 16'h1234 then extra 1 → valid with 16'h1234, then one frame_err pulse, no second valid.
- rst asserted after 6 bits of a frame, released with cs still low; master finishes the frame; then new frame 16'hBEEF → no valid for the broken frame, single valid with 16'hBEEF.
- CS_ACTIVE_LOW = 0, SAMPLE_RISING = 0, frame 16'h8001 sampled on falling sclk → data_out = 16'h8001, valid exactly once.
